// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared states, defaults and prescale helper for the UART receive controller.
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int MIN_PRESCALE_DEFAULT = 8;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    // Oversampling ratio is forced even and clamped to the minimum.
    function automatic logic [7:0] eff_prescale(input logic [7:0] pre, input logic [7:0] min_p);
        logic [7:0] e;
        e = pre & 8'hFE;
        return (e < min_p) ? min_p : e;
    endfunction
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: per-bit edge counter, data bit index and end-of-bit wrap strobe.
module uart_rx_edge_bit_cnt #(
    parameter int BW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          bit_clr,
    input  logic [7:0]    p,
    output logic [15:0]   edge_count,
    output logic [BW-1:0] bit_idx,
    output logic          wrap
);
    assign wrap = run && (edge_count == {8'd0, p} - 16'd1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_count <= '0;
            bit_idx <= '0;
        end else begin
            edge_count <= (!run || wrap) ? '0 : edge_count + 16'd1;
            bit_idx <= bit_clr ? '0 : wrap ? bit_idx + BW'(1) : bit_idx;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer driving an external majority-vote sampler.
// Define UART_RX_START_CHECK_EN to abort frames whose start-bit sample votes 1.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MIN_PRESCALE = MIN_PRESCALE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [7:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_data,
    input  logic                  sample_valid,
    output logic                  samp_en,
    output logic [15:0]           edge_count,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    state_t state, next;
    logic [7:0] p;
    logic pen, ptyp, perr, wrap, start, done, good;
    logic [BW-1:0] bit_idx;
    logic [DATA_WIDTH-1:0] shift;

    assign start = (state == IDLE) && !rx_in;
    assign done = (state == STOP) && sample_valid;
    assign good = sampled_data && !(perr && pen);
    assign samp_en = (state != IDLE);
    assign busy = (state != IDLE);

    uart_rx_edge_bit_cnt #(.BW(BW)) cnt (
        .clk(clk),
        .rst(rst),
        .run(state != IDLE),
        .bit_clr(state != DATA),
        .p(p),
        .edge_count(edge_count),
        .bit_idx(bit_idx),
        .wrap(wrap)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE: if (!rx_in) next = START;
            START: begin
                if (wrap) next = DATA;
`ifdef UART_RX_START_CHECK_EN
                if (sample_valid && sampled_data) next = IDLE;
`endif
            end
            DATA: if (wrap && bit_idx == LAST) next = pen ? PARITY : STOP;
            PARITY: if (wrap) next = STOP;
            // Leave STOP right after the vote so the next start edge is not missed.
            STOP: if (sample_valid || wrap) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            p <= '0;
            pen <= 1'b0;
            ptyp <= 1'b0;
            perr <= 1'b0;
            shift <= '0;
            data_out <= '0;
            data_valid <= 1'b0;
            par_err <= 1'b0;
            stp_err <= 1'b0;
        end else begin
            state <= next;
            if (start) begin
                p <= eff_prescale(prescale, 8'(MIN_PRESCALE));
                pen <= par_en;
                ptyp <= par_typ;
                perr <= 1'b0;
            end
            if (state == DATA && sample_valid) shift <= {sampled_data, shift[DATA_WIDTH-1:1]};
            if (state == PARITY && sample_valid) perr <= sampled_data ^ (^shift) ^ ptyp;
            stp_err <= done && !sampled_data;
            par_err <= done && perr && pen;
            data_valid <= done && good;
            if (done && good) data_out <= shift;
        end
    end
endmodule
